// File: rtl/fft_butterfly_stage.sv
// Radix-2 butterfly stage: y0=(x+w)/2, y1=(x-w)/2 with a two-register valid/ready pipeline.
// Optional macro BFLY_ROUND_EN selects round-half-up instead of floor truncation.
module fft_butterfly_stage #(
  parameter int W              = 16,
  parameter int BFLY_PER_FRAME = 4,
  localparam int IDX_W         = (BFLY_PER_FRAME > 1) ? $clog2(BFLY_PER_FRAME) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        x_r,
  input  logic [W-1:0]        x_i,
  input  logic [W-1:0]        w_r,
  input  logic [W-1:0]        w_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        y0_r,
  output logic [W-1:0]        y0_i,
  output logic [W-1:0]        y1_r,
  output logic [W-1:0]        y1_i,
  output logic                out_last,
  output logic [IDX_W-1:0]    bfly_idx
);

`ifdef BFLY_ROUND_EN
  localparam logic [W+1:0] RND = (W+2)'(1);
`else
  localparam logic [W+1:0] RND = '0;
`endif
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BFLY_PER_FRAME - 1);

  // S1: captured operands
  logic             s1_vld_q, s1_vld_d;
  logic             s1_last_q, s1_last_d;
  logic [W-1:0]     s1_xr_q, s1_xr_d, s1_xi_q, s1_xi_d;
  logic [W-1:0]     s1_wr_q, s1_wr_d, s1_wi_q, s1_wi_d;
  // S2: results
  logic             out_vld_q, out_vld_d;
  logic             out_last_q, out_last_d;
  logic [W-1:0]     y0r_q, y0r_d, y0i_q, y0i_d, y1r_q, y1r_d, y1i_q, y1i_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             s2_load, s1_adv, s1_load;
  logic [W+1:0]     xr_e, xi_e, wr_e, wi_e;
  logic [W+1:0]     sum_r, sum_i, dif_r, dif_i;

  always_comb begin
    s2_load = !out_vld_q || out_ready;
    s1_adv  = s1_vld_q && s2_load;
    in_ready = !s1_vld_q || s2_load;
    s1_load = in_valid && in_ready;

    xr_e = {{2{s1_xr_q[W-1]}}, s1_xr_q};
    xi_e = {{2{s1_xi_q[W-1]}}, s1_xi_q};
    wr_e = {{2{s1_wr_q[W-1]}}, s1_wr_q};
    wi_e = {{2{s1_wi_q[W-1]}}, s1_wi_q};
    sum_r = xr_e + wr_e + RND;
    sum_i = xi_e + wi_e + RND;
    dif_r = xr_e - wr_e + RND;
    dif_i = xi_e - wi_e + RND;
  end

  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_last_d  = s1_last_q;
    s1_xr_d    = s1_xr_q;
    s1_xi_d    = s1_xi_q;
    s1_wr_d    = s1_wr_q;
    s1_wi_d    = s1_wi_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    y0r_d      = y0r_q;
    y0i_d      = y0i_q;
    y1r_d      = y1r_q;
    y1i_d      = y1i_q;
    idx_d      = idx_q;

    if (s1_load) begin
      s1_vld_d  = 1'b1;
      s1_last_d = (idx_q == IDX_LAST);
      s1_xr_d   = x_r;
      s1_xi_d   = x_i;
      s1_wr_d   = w_r;
      s1_wi_d   = w_i;
      idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else if (s1_adv) begin
      s1_vld_d = 1'b0;
    end

    // Bits [W:1] are the arithmetic shift right by one, truncated to W bits.
    if (s2_load) begin
      out_vld_d  = s1_vld_q;
      out_last_d = s1_vld_q && s1_last_q;
      if (s1_vld_q) begin
        y0r_d = sum_r[W:1];
        y0i_d = sum_i[W:1];
        y1r_d = dif_r[W:1];
        y1i_d = dif_i[W:1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_xr_q    <= '0;
      s1_xi_q    <= '0;
      s1_wr_q    <= '0;
      s1_wi_q    <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      y0r_q      <= '0;
      y0i_q      <= '0;
      y1r_q      <= '0;
      y1i_q      <= '0;
      idx_q      <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_last_q  <= s1_last_d;
      s1_xr_q    <= s1_xr_d;
      s1_xi_q    <= s1_xi_d;
      s1_wr_q    <= s1_wr_d;
      s1_wi_q    <= s1_wi_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      y0r_q      <= y0r_d;
      y0i_q      <= y0i_d;
      y1r_q      <= y1r_d;
      y1i_q      <= y1i_d;
      idx_q      <= idx_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_last  = out_last_q;
  assign y0_r      = y0r_q;
  assign y0_i      = y0i_q;
  assign y1_r      = y1r_q;
  assign y1_i      = y1i_q;
  assign bfly_idx  = idx_q;

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Directed bench for fft_butterfly_stage: arithmetic corners, streaming, backpressure, reset.
module tb_fft_butterfly_stage;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] x_r = '0, x_i = '0, w_r = '0, w_i = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] y0_r, y0_i, y1_r, y1_i;
  logic                out_last;
  logic [1:0]          bfly_idx;

  int total = 0;
  int bad   = 0;

  fft_butterfly_stage #(.W(W), .BFLY_PER_FRAME(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_r(x_r), .x_i(x_i), .w_r(w_r), .w_i(w_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0_r(y0_r), .y0_i(y0_i), .y1_r(y1_r), .y1_i(y1_i),
    .out_last(out_last), .bfly_idx(bfly_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One operand pair through an idle pipe; outputs examined two cycles after the handshake.
  task automatic send_one(input int xr, input int xi, input int wr, input int wi,
                          input int e0r, input int e0i, input int e1r, input int e1i,
                          input int e_last, input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x_r = W'(xr); x_i = W'(xi); w_r = W'(wr); w_i = W'(wi);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1_vld"}, int'(out_valid), 0);
    @(negedge clk);
    chk({tag, "_vld"}, int'(out_valid), 1);
    chk({tag, "_y0r"}, int'(y0_r), e0r);
    chk({tag, "_y0i"}, int'(y0_i), e0i);
    chk({tag, "_y1r"}, int'(y1_r), e1r);
    chk({tag, "_y1i"}, int'(y1_i), e1i);
    chk({tag, "_last"}, int'(out_last), e_last);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Eight pairs x=(10k,-4k), w=(2k,0), k=1..8 -> y0=(6k,-2k), y1=(4k,-2k).
  task automatic run_stream(input int stall_at, input int stall_len, input string tag);
    int sent = 0, got = 0, cyc = 0, first = -1, last = -1;
    logic signed [W-1:0] hold0 = '0, hold1 = '0;
    logic hold_vld = 1'b0, hold_last = 1'b0;
    bit saw_block = 1'b0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (sent < 8) begin
        in_valid = 1'b1;
        x_r = W'(10 * (sent + 1));
        x_i = W'(-4 * (sent + 1));
        w_r = W'(2 * (sent + 1));
        w_i = '0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (hold_vld) begin
        chk({tag, "_hold_y0"}, int'(y0_r), int'(hold0));
        chk({tag, "_hold_y1"}, int'(y1_r), int'(hold1));
        chk({tag, "_hold_last"}, int'(out_last), int'(hold_last));
      end
      hold_vld = out_valid && !out_ready;
      hold0 = y0_r; hold1 = y1_r; hold_last = out_last;
      if (!in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) begin
        chk({tag, "_idx"}, int'(bfly_idx), sent % 4);
        sent++;
      end
      if (out_valid && out_ready) begin
        chk({tag, "_y0r"}, int'(y0_r), 6 * (got + 1));
        chk({tag, "_y0i"}, int'(y0_i), -2 * (got + 1));
        chk({tag, "_y1r"}, int'(y1_r), 4 * (got + 1));
        chk({tag, "_y1i"}, int'(y1_i), -2 * (got + 1));
        chk({tag, "_last"}, int'(out_last), (got % 4 == 3) ? 1 : 0);
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      cyc++;
    end
    chk({tag, "_count"}, got, 8);
    if (stall_len == 0) begin
      chk({tag, "_span"}, last - first, 7);
      chk({tag, "_never_blocked"}, int'(saw_block), 0);
    end else begin
      chk({tag, "_blocked"}, int'(saw_block), 1);
      chk({tag, "_span"}, last - first, 7 + stall_len);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({tag, "_drained"}, int'(out_valid), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_idx", int'(bfly_idx), 0);
    chk("rst_y0r", int'(y0_r), 0);
    chk("rst_y1i", int'(y1_i), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);

    send_one(1000, 0, 200, 0, 600, 0, 400, 0, 0, "basic");
`ifdef BFLY_ROUND_EN
    send_one(3, 0, 0, 0, 2, 0, 2, 0, 0, "pos3");
    send_one(-3, 0, 0, 0, -1, 0, -1, 0, 0, "neg3");
    send_one(32767, 0, 32767, 0, 32767, 0, 0, 0, 1, "max");
    send_one(-32768, 0, 32767, 0, 0, 0, -32767, 0, 0, "min");
`else
    send_one(3, 0, 0, 0, 1, 0, 1, 0, 0, "pos3");
    send_one(-3, 0, 0, 0, -2, 0, -2, 0, 0, "neg3");
    send_one(32767, 0, 32767, 0, 32767, 0, 0, 0, 1, "max");
    send_one(-32768, 0, 32767, 0, -1, 0, -32768, 0, 0, "min");
`endif
    chk("idx_after_wrap", int'(bfly_idx), 1);

    do_reset();
    run_stream(100, 0, "stream");
    do_reset();
    run_stream(3, 3, "bp");

    // Two inputs held in the pipe, then reset: nothing may emerge afterwards.
    do_reset();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    x_r = W'(500); w_r = W'(100); x_i = '0; w_i = '0;
    @(negedge clk);
    x_r = W'(700);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_idx_before", int'(bfly_idx), 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("mid_rst_vld", int'(out_valid), 0);
    chk("mid_rst_idx", int'(bfly_idx), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_rst_no_stale", int'(out_valid), 0);
    end
    send_one(8, 2, 4, -2, 6, 0, 2, 2, 0, "after_rst");
    chk("after_rst_idx", int'(bfly_idx), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
